// File: rtl/gpu_isa_pkg.sv
// gpu_isa_pkg: shared instruction-set definitions for the filter-GPU encoder.
//   op_t        : instruction class carried in bits [27:26]
//   COND_AL     : "always" condition code
//   enc_state_t : encoder session state
//   csum_step   : one step of the rotate-xor program checksum
package gpu_isa_pkg;

   typedef enum logic [1:0] {
      OP_DP  = 2'b00,
      OP_MEM = 2'b01,
      OP_BR  = 2'b10,
      OP_ILL = 2'b11
   } op_t;

   localparam logic [3:0] COND_AL = 4'hE;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      LOAD  = 2'b01,
      WRITE = 2'b10,
      DONE  = 2'b11
   } enc_state_t;

   // Rotate the running checksum left by one, then fold in the new word.
   function automatic logic [31:0] csum_step(input logic [31:0] c, input logic [31:0] w);
      return {c[30:0], c[31]} ^ w;
   endfunction

endpackage

// File: rtl/instr_pack.sv
// instr_pack: combinational packer from instruction fields to a 32-bit word.
// Ports:
//   cond[3:0], op[1:0], funct[5:0], rn[3:0], rd[3:0], src2[11:0], imm24[23:0] : fields
//   word[31:0] : packed instruction (zero for the illegal class)
//   illegal    : op selects the illegal class; the tuple must not be written
module instr_pack
   import gpu_isa_pkg::*;
(
   input  logic [3:0]  cond,
   input  logic [1:0]  op,
   input  logic [5:0]  funct,
   input  logic [3:0]  rn,
   input  logic [3:0]  rd,
   input  logic [11:0] src2,
   input  logic [23:0] imm24,
   output logic [31:0] word,
   output logic        illegal
);

   // Field packing by instruction class; branches keep only funct[5:4].
   always_comb begin
      word    = 32'h0000_0000;
      illegal = 1'b0;
      case (op_t'(op))
         OP_DP, OP_MEM: word = {cond, op, funct, rn, rd, src2};
         OP_BR:         word = {cond, op, funct[5:4], imm24};
         OP_ILL:        illegal = 1'b1;
         default:       illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: accepts instruction field tuples over valid/ready, packs them and
// writes them sequentially into instruction memory starting at word 0.
// Ports:
//   clk, reset (async, active high), start (begin session in IDLE/DONE)
//   fld_valid/fld_ready/fld_last and field inputs fld_cond..fld_imm24
//   imem_we/imem_addr/imem_wdata : one write strobe per encoded word
//   busy, done, count            : session status
//   err_illegal, err_ovf         : sticky session errors
//   csum (only when CHECKSUM_EN is defined) : rotate-xor checksum of written words
// Configuration macro: CHECKSUM_EN.
module instr_encoder
   import gpu_isa_pkg::*;
#(
   parameter int ADDR_W = 10
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              fld_valid,
   output logic              fld_ready,
   input  logic              fld_last,
   input  logic [3:0]        fld_cond,
   input  logic [1:0]        fld_op,
   input  logic [5:0]        fld_funct,
   input  logic [3:0]        fld_rn,
   input  logic [3:0]        fld_rd,
   input  logic [11:0]       fld_src2,
   input  logic [23:0]       fld_imm24,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   count,
`ifdef CHECKSUM_EN
   output logic [31:0]       csum,
`endif
   output logic              err_illegal,
   output logic              err_ovf
);

   localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

   enc_state_t        state_r, next_s;
   logic [ADDR_W-1:0] addr_r;
   logic [ADDR_W:0]   count_r;
   logic [31:0]       word_r;
   logic              last_r;
   logic              ill_r, ovf_r;
   logic              ready_r, we_r, busy_r, done_r;
   logic              ready_s, we_s, busy_s, done_s;
   logic [31:0]       pack_word_s;
   logic              pack_ill_s;
   logic              accept_s, restart_s, full_s;

   instr_pack u_pack (
      .cond    (fld_cond),
      .op      (fld_op),
      .funct   (fld_funct),
      .rn      (fld_rn),
      .rd      (fld_rd),
      .src2    (fld_src2),
      .imm24   (fld_imm24),
      .word    (pack_word_s),
      .illegal (pack_ill_s)
   );

   // fld_ready is registered from next_s == LOAD, so it equals state_r == LOAD.
   assign accept_s  = (state_r == LOAD) && fld_valid;
   assign restart_s = ((state_r == IDLE) || (state_r == DONE)) && start;
   assign full_s    = (addr_r == ADDR_MAX);

   // Next-state logic for the load session.
   always_comb begin
      next_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) next_s = LOAD;
            else       next_s = IDLE;
         end
         LOAD: begin
            if (accept_s) begin
               if (pack_ill_s) next_s = fld_last ? DONE : LOAD;
               else            next_s = WRITE;
            end else begin
               next_s = LOAD;
            end
         end
         WRITE: begin
            if (last_r || full_s) next_s = DONE;
            else                  next_s = LOAD;
         end
         DONE: begin
            if (start) next_s = LOAD;
            else       next_s = DONE;
         end
         default: next_s = IDLE;
      endcase
   end

   // Status outputs decoded from the upcoming state so they can be registered.
   always_comb begin
      ready_s = (next_s == LOAD);
      we_s    = (next_s == WRITE);
      busy_s  = (next_s == LOAD) || (next_s == WRITE);
      done_s  = (next_s == DONE);
   end

   // State register and registered status outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
         ready_r <= 1'b0;
         we_r    <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= next_s;
         ready_r <= ready_s;
         we_r    <= we_s;
         busy_r  <= busy_s;
         done_r  <= done_s;
      end
   end

   // Word capture, address/count advance and sticky error flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_r  <= {ADDR_W{1'b0}};
         count_r <= {(ADDR_W+1){1'b0}};
         word_r  <= 32'h0000_0000;
         last_r  <= 1'b0;
         ill_r   <= 1'b0;
         ovf_r   <= 1'b0;
      end else if (restart_s) begin
         addr_r  <= {ADDR_W{1'b0}};
         count_r <= {(ADDR_W+1){1'b0}};
         last_r  <= 1'b0;
         ill_r   <= 1'b0;
         ovf_r   <= 1'b0;
      end else if (accept_s) begin
         if (pack_ill_s) begin
            ill_r <= 1'b1;
         end else begin
            word_r <= pack_word_s;
            last_r <= fld_last;
         end
      end else if (state_r == WRITE) begin
         count_r <= count_r + {{ADDR_W{1'b0}}, 1'b1};
         // The address saturates at the top word instead of wrapping.
         if (!full_s) addr_r <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
         if (full_s && !last_r) ovf_r <= 1'b1;
      end
   end

`ifdef CHECKSUM_EN
   logic [31:0] csum_r;

   // Running checksum over every word written in the session.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         csum_r <= 32'h0000_0000;
      end else if (restart_s) begin
         csum_r <= 32'h0000_0000;
      end else if (state_r == WRITE) begin
         csum_r <= csum_step(csum_r, word_r);
      end
   end

   assign csum = csum_r;
`endif

   assign fld_ready   = ready_r;
   assign imem_we     = we_r;
   assign imem_addr   = addr_r;
   assign imem_wdata  = word_r;
   assign busy        = busy_r;
   assign done        = done_r;
   assign count       = count_r;
   assign err_illegal = ill_r;
   assign err_ovf     = ovf_r;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed self-checking bench for instr_encoder.
// DUT a uses ADDR_W=10, DUT b uses ADDR_W=2 for the full-memory case.
// Checksum checks are compiled in when CHECKSUM_EN is defined.
module tb_instr_encoder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, start_a, start_b, valid_a, valid_b, f_last;
   logic [3:0]  f_cond, f_rn, f_rd;
   logic [1:0]  f_op;
   logic [5:0]  f_funct;
   logic [11:0] f_src2;
   logic [23:0] f_imm24;

   logic        ready_a, we_a, busy_a, done_a, ill_a, ovf_a;
   logic [9:0]  addr_a;
   logic [10:0] count_a;
   logic [31:0] wdata_a;
   logic        ready_b, we_b, busy_b, done_b, ill_b, ovf_b;
   logic [1:0]  addr_b;
   logic [2:0]  count_b;
   logic [31:0] wdata_b;
`ifdef CHECKSUM_EN
   logic [31:0] csum_a, csum_b;
`endif

   instr_encoder #(.ADDR_W(10)) dut_a (
      .clk(clk), .reset(reset), .start(start_a),
      .fld_valid(valid_a), .fld_ready(ready_a), .fld_last(f_last),
      .fld_cond(f_cond), .fld_op(f_op), .fld_funct(f_funct), .fld_rn(f_rn),
      .fld_rd(f_rd), .fld_src2(f_src2), .fld_imm24(f_imm24),
      .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wdata_a),
      .busy(busy_a), .done(done_a), .count(count_a),
`ifdef CHECKSUM_EN
      .csum(csum_a),
`endif
      .err_illegal(ill_a), .err_ovf(ovf_a)
   );

   instr_encoder #(.ADDR_W(2)) dut_b (
      .clk(clk), .reset(reset), .start(start_b),
      .fld_valid(valid_b), .fld_ready(ready_b), .fld_last(f_last),
      .fld_cond(f_cond), .fld_op(f_op), .fld_funct(f_funct), .fld_rn(f_rn),
      .fld_rd(f_rd), .fld_src2(f_src2), .fld_imm24(f_imm24),
      .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wdata_b),
      .busy(busy_b), .done(done_b), .count(count_b),
`ifdef CHECKSUM_EN
      .csum(csum_b),
`endif
      .err_illegal(ill_b), .err_ovf(ovf_b)
   );

   // Write logs, sampled on the falling edge.
   logic [31:0] la_data [0:63];
   logic [9:0]  la_addr [0:63];
   int          na = 0;
   logic [31:0] lb_data [0:63];
   logic [1:0]  lb_addr [0:63];
   int          nb = 0;

   always @(negedge clk) begin
      if (we_a === 1'b1 && na < 64) begin
         la_data[na] = wdata_a;
         la_addr[na] = addr_a;
         na++;
      end
   end

   always @(negedge clk) begin
      if (we_b === 1'b1 && nb < 64) begin
         lb_data[nb] = wdata_b;
         lb_addr[nb] = addr_b;
         nb++;
      end
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Presents one tuple to DUT a (sel=0) or b (sel=1); called on a falling edge.
   task automatic send(input bit sel, input logic [1:0] o, input logic [3:0] c,
                       input logic [5:0] f, input logic [3:0] n, input logic [3:0] d,
                       input logic [11:0] s, input logic [23:0] i, input logic l);
      int w;
      w = 0;
      while (((sel ? ready_b : ready_a) !== 1'b1) && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk("hs_ready", {31'b0, (sel ? ready_b : ready_a)}, 32'h1);
      f_op = o; f_cond = c; f_funct = f; f_rn = n; f_rd = d;
      f_src2 = s; f_imm24 = i; f_last = l;
      if (sel) valid_b = 1'b1;
      else     valid_a = 1'b1;
      @(negedge clk);
      valid_a = 1'b0;
      valid_b = 1'b0;
      f_last  = 1'b0;
   endtask

   task automatic pulse_start(input bit sel);
      if (sel) start_b = 1'b1;
      else     start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   int a0, b0, fill0;

   initial begin
      reset = 1'b1; start_a = 1'b0; start_b = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
      f_last = 1'b0; f_cond = 4'h0; f_rn = 4'h0; f_rd = 4'h0; f_op = 2'b00;
      f_funct = 6'h00; f_src2 = 12'h000; f_imm24 = 24'h000000;
      @(negedge clk);
      @(negedge clk);
      chk("rst_busy",  {31'b0, busy_a},  32'h0);
      chk("rst_done",  {31'b0, done_a},  32'h0);
      chk("rst_ready", {31'b0, ready_a}, 32'h0);
      chk("rst_we",    {31'b0, we_a},    32'h0);
      chk("rst_count", {21'b0, count_a}, 32'h0);
      reset = 1'b0;
      @(negedge clk);

      // DP encode, one-cycle write latency after handshake
      pulse_start(1'b0);
      chk("t2_busy", {31'b0, busy_a}, 32'h1);
      send(1'b0, 2'b00, 4'hE, 6'b101000, 4'h1, 4'h2, 12'h005, 24'h0, 1'b0);
      chk("t2_we",    {31'b0, we_a},    32'h1);
      chk("t2_addr",  {22'b0, addr_a},  32'h0);
      chk("t2_wdata", wdata_a,          32'hE2812005);
      chk("t2_ready", {31'b0, ready_a}, 32'h0);
      @(negedge clk);
      chk("t2_count", {21'b0, count_a}, 32'h1);

      // Reset in the middle of a WRITE cycle
      send(1'b0, 2'b00, 4'hE, 6'b101000, 4'h1, 4'h2, 12'h005, 24'h0, 1'b0);
      #2 reset = 1'b1;
      #1;
      chk("t1_we",    {31'b0, we_a},    32'h0);
      chk("t1_busy",  {31'b0, busy_a},  32'h0);
      chk("t1_done",  {31'b0, done_a},  32'h0);
      chk("t1_count", {21'b0, count_a}, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // MEM then BR with last
      pulse_start(1'b0);
      a0 = na;
      send(1'b0, 2'b01, 4'hE, 6'b011001, 4'h0, 4'h3, 12'h004, 24'h0, 1'b0);
      send(1'b0, 2'b10, 4'hE, 6'b100000, 4'h0, 4'h0, 12'h000, 24'h000003, 1'b1);
      @(negedge clk);
      chk("t3_nwr",  na - a0, 32'd2);
      chk("t3_a0",   {22'b0, la_addr[a0]},   32'h0);
      chk("t3_d0",   la_data[a0],            32'hE5903004);
      chk("t3_a1",   {22'b0, la_addr[a0+1]}, 32'h1);
      chk("t3_d1",   la_data[a0+1],          32'hEA000003);
      chk("t3_done", {31'b0, done_a},  32'h1);
      chk("t3_busy", {31'b0, busy_a},  32'h0);
      chk("t3_count", {21'b0, count_a}, 32'h2);

      // Illegal tuple between two DP tuples
      pulse_start(1'b0);
      chk("t4_done_clr", {31'b0, done_a}, 32'h0);
      a0 = na;
      send(1'b0, 2'b00, 4'hE, 6'b101000, 4'h1, 4'h2, 12'h005, 24'h0, 1'b0);
      send(1'b0, 2'b11, 4'hE, 6'b111111, 4'h5, 4'h6, 12'h777, 24'h0, 1'b0);
      chk("t4_ill_now", {31'b0, ill_a}, 32'h1);
      send(1'b0, 2'b00, 4'hE, 6'b000100, 4'h3, 4'h4, 12'h0FF, 24'h0, 1'b1);
      @(negedge clk);
      chk("t4_nwr",  na - a0, 32'd2);
      chk("t4_a0",   {22'b0, la_addr[a0]},   32'h0);
      chk("t4_d0",   la_data[a0],            32'hE2812005);
      chk("t4_a1",   {22'b0, la_addr[a0+1]}, 32'h1);
      chk("t4_d1",   la_data[a0+1],          32'hE04340FF);
      chk("t4_ill",  {31'b0, ill_a},  32'h1);
      chk("t4_done", {31'b0, done_a}, 32'h1);
      chk("t4_count", {21'b0, count_a}, 32'h2);
      pulse_start(1'b0);
      chk("t4_ill_clr", {31'b0, ill_a}, 32'h0);
      chk("t4_cnt_clr", {21'b0, count_a}, 32'h0);

      // Full memory on the 4-word instance
      pulse_start(1'b1);
      b0 = nb;
      for (int k = 0; k < 4; k++)
         send(1'b1, 2'b00, 4'hE, 6'h00, 4'h0, 4'h0, 12'(k), 24'h0, 1'b0);
      @(negedge clk);
      chk("t5_nwr", nb - b0, 32'd4);
      for (int k = 0; k < 4; k++) begin
         chk("t5_addr", {30'b0, lb_addr[b0+k]}, 32'(k));
         chk("t5_data", lb_data[b0+k], 32'hE0000000 | 32'(k));
      end
      chk("t5_ovf",   {31'b0, ovf_b},   32'h1);
      chk("t5_done",  {31'b0, done_b},  32'h1);
      chk("t5_ready", {31'b0, ready_b}, 32'h0);
      chk("t5_count", {29'b0, count_b}, 32'h4);
      fill0 = nb;
      f_op = 2'b00; f_cond = 4'hE; f_src2 = 12'h004;
      valid_b = 1'b1;
      repeat (4) @(negedge clk);
      valid_b = 1'b0;
      @(negedge clk);
      chk("t5_no5th", nb - fill0, 32'd0);
      chk("t5_count_hold", {29'b0, count_b}, 32'h4);
      chk("t5_busy", {31'b0, busy_b}, 32'h0);

`ifdef CHECKSUM_EN
      // Checksum: DUT a is in LOAD after the last start
      chk("t6_csum_clr", csum_a, 32'h0);
      send(1'b0, 2'b00, 4'h0, 6'h00, 4'h0, 4'h0, 12'h001, 24'h0, 1'b0);
      @(negedge clk);
      chk("t6_csum1", csum_a, 32'h00000001);
      send(1'b0, 2'b00, 4'h0, 6'h00, 4'h0, 4'h0, 12'h002, 24'h0, 1'b1);
      @(negedge clk);
      chk("t6_csum2", csum_a, 32'h00000000);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
